// File: rtl/parking_lot_pkg.sv
// Shared types, defaults and helpers for the parking request issuer.
package parking_lot_pkg;

  localparam int unsigned DEPTH_DEF   = 4;
  localparam int unsigned TIMEOUT_DEF = 64;
  localparam int unsigned PLATE_W     = 16;
  localparam int unsigned CNT_W       = 3;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ISSUE      = 2'd1,
    WAIT_BOARD = 2'd2,
    WAIT_EXIT  = 2'd3
  } issuer_state_t;

  // One queued request: plate as 4 BCD digits plus direction (1 = enter).
  typedef struct packed {
    logic [PLATE_W-1:0] plate;
    logic               dir;
  } park_req_t;

  // True when every nibble of the plate is a decimal digit.
  function automatic logic bcd_valid(input logic [PLATE_W-1:0] plate);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (plate[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/parking_req_fifo.sv
// Request queue: DEPTH-entry FIFO with registered occupancy count.
module parking_req_fifo
  import parking_lot_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  park_req_t        i_data,
  input  logic             i_pop,
  output park_req_t        o_head,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  localparam int unsigned      PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  park_req_t        r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  // Entry storage; contents need no reset because count gates every use.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointers wrap at DEPTH; count tracks push/pop including simultaneous ones.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/parking_request_issuer.sv
// Queues parking requests and issues them one at a time to the lot controller,
// waiting for the elevator to be boarded and vacated or for a timeout.
module parking_request_issuer
  import parking_lot_pkg::*;
#(
  parameter int unsigned DEPTH   = DEPTH_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               req_valid,
  input  logic [PLATE_W-1:0] req_plate,
  input  logic               req_dir,
  output logic               req_ready,
  output logic               req_error,
  output logic [PLATE_W-1:0] license_plate,
  output logic               in_mode,
  output logic               out_mode,
  input  logic [PLATE_W-1:0] moving,
  output logic               issue_done,
  output logic               issue_timeout,
  output logic [CNT_W-1:0]   count
);

  localparam int unsigned      TMR_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  issuer_state_t      r_state;
  issuer_state_t      w_state_nxt;
  logic [TMR_W-1:0]   r_timer;
  logic [TMR_W-1:0]   w_timer_nxt;
  logic               w_done;
  logic               w_tmo;
  logic               w_pop;
  logic               w_push;
  logic               w_bcd_ok;
  logic               w_store;
  logic               w_full;
  logic               w_empty;
  logic [CNT_W-1:0]   w_count;
  park_req_t          w_req;
  park_req_t          w_head;
  logic               r_req_error;
  logic               r_issue_done;
  logic               r_issue_timeout;
  logic               r_in_mode;
  logic               r_out_mode;
  logic [PLATE_W-1:0] r_license_plate;

  assign req_ready = ~w_full;
  assign w_push    = req_valid & req_ready;
  assign w_bcd_ok  = bcd_valid(req_plate);
  assign w_store   = w_push & w_bcd_ok;
  assign w_req     = park_req_t'{plate: req_plate, dir: req_dir};
  assign w_pop     = w_done | w_tmo;

  parking_req_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (clock),
    .i_rst_n (reset),
    .i_push  (w_store),
    .i_data  (w_req),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // State and wait-timer registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_timer <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
    end
  end

  // Next state, timer and completion events; a vacated elevator beats the timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_done      = 1'b0;
    w_tmo       = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) w_state_nxt = ISSUE;
      end
      ISSUE: begin
        w_state_nxt = WAIT_BOARD;
        w_timer_nxt = '0;
      end
      WAIT_BOARD: begin
        if (r_timer == TMR_LAST) begin
          w_tmo       = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_timer_nxt = r_timer + TMR_W'(1);
          if (moving != '0) w_state_nxt = WAIT_EXIT;
        end
      end
      WAIT_EXIT: begin
        if (moving == '0) begin
          w_done      = 1'b1;
          w_state_nxt = IDLE;
        end else if (r_timer == TMR_LAST) begin
          w_tmo       = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_timer_nxt = r_timer + TMR_W'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Registered command and status outputs; the command holds for one cycle per issue.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_req_error     <= 1'b0;
      r_issue_done    <= 1'b0;
      r_issue_timeout <= 1'b0;
      r_in_mode       <= 1'b0;
      r_out_mode      <= 1'b0;
      r_license_plate <= '0;
    end else begin
      r_req_error     <= w_push & ~w_bcd_ok;
      r_issue_done    <= w_done;
      r_issue_timeout <= w_tmo;
      r_in_mode       <= (r_state == ISSUE) & w_head.dir;
      r_out_mode      <= (r_state == ISSUE) & ~w_head.dir;
      r_license_plate <= (r_state == ISSUE) ? w_head.plate : '0;
    end
  end

  assign req_error     = r_req_error;
  assign issue_done    = r_issue_done;
  assign issue_timeout = r_issue_timeout;
  assign in_mode       = r_in_mode;
  assign out_mode      = r_out_mode;
  assign license_plate = r_license_plate;
  assign count         = w_count;

endmodule

// File: tb/tb_parking_request_issuer.sv
// Bench for parking_request_issuer: timestamp-based reference model checked
// every cycle, plus directed scenarios with hand-computed literal checks.
module tb_parking_request_issuer;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 64;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic [15:0] req_plate = 16'h0;
  logic        req_dir = 1'b0;
  logic        req_ready;
  logic        req_error;
  logic [15:0] license_plate;
  logic        in_mode;
  logic        out_mode;
  logic [15:0] moving = 16'h0;
  logic        issue_done;
  logic        issue_timeout;
  logic [2:0]  count;

  parking_request_issuer #(
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_plate     (req_plate),
    .req_dir       (req_dir),
    .req_ready     (req_ready),
    .req_error     (req_error),
    .license_plate (license_plate),
    .in_mode       (in_mode),
    .out_mode      (out_mode),
    .moving        (moving),
    .issue_done    (issue_done),
    .issue_timeout (issue_timeout),
    .count         (count)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- reference model ----------------
  typedef struct {
    logic [15:0] plate;
    logic        dir;
  } mreq_t;

  mreq_t       mq[$];
  mreq_t       m_new;
  int          m_cyc = 0;
  int          m_start = 0;
  int          m_issue_at = 0;
  int          m_idle_from = 0;
  int          m_pre_sz = 0;
  int          m_age = 0;
  bit          m_active = 1'b0;
  bit          m_pending = 1'b0;
  bit          m_boarded = 1'b0;
  bit          m_pop = 1'b0;
  logic        e_err = 1'b0;
  logic        e_done = 1'b0;
  logic        e_tmo = 1'b0;
  logic        e_in = 1'b0;
  logic        e_out = 1'b0;
  logic [15:0] e_plate = 16'h0;

  function automatic bit plate_is_decimal(input logic [15:0] p);
    int v;
    v = 32'(p);
    for (int d = 0; d < 4; d++) begin
      if ((v % 16) > 9) return 1'b0;
      v = v / 16;
    end
    return 1'b1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", nm, m_cyc, act, exp);
  endtask

  // Cycle n = interval after edge n. At each edge the model resolves what
  // happened during cycle n-1 and predicts the outputs visible in cycle n.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      mq.delete();
      m_cyc = 0; m_idle_from = 0; m_start = 0; m_issue_at = 0;
      m_active = 1'b0; m_pending = 1'b0; m_boarded = 1'b0;
      e_err = 1'b0; e_done = 1'b0; e_tmo = 1'b0;
      e_in = 1'b0; e_out = 1'b0; e_plate = 16'h0;
    end else begin
      m_cyc = m_cyc + 1;
      m_pre_sz = mq.size();
      e_err = 1'b0; e_done = 1'b0; e_tmo = 1'b0;
      e_in = 1'b0; e_out = 1'b0; e_plate = 16'h0;
      m_pop = 1'b0;
      // Request in service: waited cycles 0..TIMEOUT-1 after the command cycle.
      if (m_active) begin
        m_age = m_cyc - 1 - m_start;
        if (m_boarded && moving == 16'h0) begin
          e_done = 1'b1; m_pop = 1'b1;
        end else if (m_age == TIMEOUT - 1) begin
          e_tmo = 1'b1; m_pop = 1'b1;
        end else if (moving != 16'h0) begin
          m_boarded = 1'b1;
        end
      end
      // An idle cycle that sees a non-empty queue yields a command two cycles later.
      if (!m_active && !m_pending && (m_cyc - 1) >= m_idle_from && m_pre_sz > 0) begin
        m_pending  = 1'b1;
        m_issue_at = m_cyc + 1;
      end
      if (m_pop) begin
        void'(mq.pop_front());
        m_active    = 1'b0;
        m_idle_from = m_cyc;
      end
      if (req_valid && m_pre_sz < DEPTH) begin
        if (plate_is_decimal(req_plate)) begin
          m_new.plate = req_plate;
          m_new.dir   = req_dir;
          mq.push_back(m_new);
        end else begin
          e_err = 1'b1;
        end
      end
      if (m_pending && m_issue_at == m_cyc) begin
        m_pending = 1'b0;
        m_active  = 1'b1;
        m_start   = m_cyc;
        m_boarded = 1'b0;
        e_in      = mq[0].dir;
        e_out     = ~mq[0].dir;
        e_plate   = mq[0].plate;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clock) begin
    if (reset) begin
      chk("req_ready",     32'(req_ready),     32'(mq.size() < DEPTH));
      chk("count",         32'(count),         32'(mq.size()));
      chk("req_error",     32'(req_error),     32'(e_err));
      chk("issue_done",    32'(issue_done),    32'(e_done));
      chk("issue_timeout", 32'(issue_timeout), 32'(e_tmo));
      chk("in_mode",       32'(in_mode),       32'(e_in));
      chk("out_mode",      32'(out_mode),      32'(e_out));
      chk("license_plate", 32'(license_plate), 32'(e_plate));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clock);
  endtask

  task automatic push(input logic [15:0] p, input logic d);
    req_valid = 1'b1;
    req_plate = p;
    req_dir   = d;
    @(negedge clock);
    req_valid = 1'b0;
  endtask

  task automatic wait_issue(output logic got_in, output logic got_out, output logic [15:0] got_plate);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (in_mode || out_mode) begin
        seen = 1'b1;
        break;
      end
      @(negedge clock);
    end
    chk("issue_seen", 32'(seen), 32'd1);
    got_in    = in_mode;
    got_out   = out_mode;
    got_plate = license_plate;
  endtask

  task automatic serve(output logic got_in, output logic got_out, output logic [15:0] got_plate);
    wait_issue(got_in, got_out, got_plate);
    moving = (got_plate == 16'h0) ? 16'h0001 : got_plate;
    repeat (2) @(negedge clock);
    moving = 16'h0;
    @(negedge clock);
    chk("serve_done", 32'(issue_done), 32'd1);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    logic        gi, go;
    logic [15:0] gp;
    logic [15:0] plates [5];
    int          k, n_to;
    bit          hit;

    plates[0] = 16'h1111; plates[1] = 16'h2222; plates[2] = 16'h3333;
    plates[3] = 16'h4444; plates[4] = 16'h5555;

    repeat (3) tick();
    chk("rst_in_mode",   32'(in_mode),   32'd0);
    chk("rst_count",     32'(count),     32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    reset = 1'b1;
    tick();

    // Single enter request: command exactly two cycles after the push edge.
    push(16'h9423, 1'b1);
    tick();
    chk("s1_in_early", 32'(in_mode), 32'd0);
    tick();
    chk("s1_in_mode",  32'(in_mode),       32'd1);
    chk("s1_out_mode", 32'(out_mode),      32'd0);
    chk("s1_plate",    32'(license_plate), 32'h9423);
    moving = 16'h9423;
    tick();
    chk("s1_in_once", 32'(in_mode), 32'd0);
    repeat (2) tick();
    moving = 16'h0;
    tick();
    chk("s1_done",  32'(issue_done), 32'd1);
    chk("s1_count", 32'(count),      32'd0);

    // Enter then exit of the same plate, issued in push order.
    push(16'h8754, 1'b1);
    push(16'h8754, 1'b0);
    serve(gi, go, gp);
    chk("s2_first_in",    32'(gi), 32'd1);
    chk("s2_first_plate", 32'(gp), 32'h8754);
    serve(gi, go, gp);
    chk("s2_second_out",   32'(go), 32'd1);
    chk("s2_second_in",    32'(gi), 32'd0);
    tick();

    // Full queue with nobody boarding: fifth push refused, all four time out.
    moving = 16'h0;
    for (int i = 0; i < 5; i++) push(plates[i], 1'(i % 2));
    chk("s3_count_full", 32'(count),     32'd4);
    chk("s3_ready_low",  32'(req_ready), 32'd0);
    hit = 1'b0;
    k = -1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (issue_timeout) begin
        k = i + 1;
        hit = 1'b1;
        break;
      end
    end
    chk("s3_first_timeout_gap", 32'(k), 32'd62);
    n_to = hit ? 1 : 0;
    for (int i = 0; i < 4 * (TIMEOUT + 5); i++) begin
      if (count == 3'd0) break;
      tick();
      if (issue_timeout) n_to++;
    end
    chk("s3_timeouts", 32'(n_to),  32'd4);
    chk("s3_drained",  32'(count), 32'd0);
    tick();

    // Non-decimal plate is dropped with an error pulse.
    push(16'h9A23, 1'b1);
    chk("s4_error", 32'(req_error), 32'd1);
    chk("s4_count", 32'(count),     32'd0);
    tick();
    chk("s4_error_pulse", 32'(req_error), 32'd0);
    repeat (4) tick();
    chk("s4_no_issue", 32'(in_mode), 32'd0);

    // Reset in the middle of a command with three queued.
    push(16'h1234, 1'b1);
    push(16'h2345, 1'b0);
    push(16'h3456, 1'b1);
    wait_issue(gi, go, gp);
    chk("s5_count_before", 32'(count), 32'd3);
    #2 reset = 1'b0;
    #1;
    chk("s5_in_dropped",  32'(in_mode),       32'd0);
    chk("s5_plate_clr",   32'(license_plate), 32'd0);
    chk("s5_count_clr",   32'(count),         32'd0);
    chk("s5_ready",       32'(req_ready),     32'd1);
    repeat (2) tick();
    reset     = 1'b1;
    req_valid = 1'b1;
    req_plate = 16'h4321;
    req_dir   = 1'b0;
    tick();
    req_valid = 1'b0;
    chk("s5_first_push", 32'(count), 32'd1);
    serve(gi, go, gp);
    chk("s5_plate_after", 32'(gp), 32'h4321);
    chk("s5_out_after",   32'(go), 32'd1);
    tick();

    // Push coinciding with a completion keeps count and FIFO order.
    push(16'h1357, 1'b1);
    push(16'h2468, 1'b0);
    wait_issue(gi, go, gp);
    chk("s6_a_plate", 32'(gp), 32'h1357);
    moving = 16'h1357;
    repeat (2) tick();
    moving    = 16'h0;
    req_valid = 1'b1;
    req_plate = 16'h9753;
    req_dir   = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("s6_count_same", 32'(count),      32'd2);
    chk("s6_done",       32'(issue_done), 32'd1);
    serve(gi, go, gp);
    chk("s6_b_plate", 32'(gp), 32'h2468);
    chk("s6_b_out",   32'(go), 32'd1);
    serve(gi, go, gp);
    chk("s6_c_plate", 32'(gp), 32'h9753);
    chk("s6_c_in",    32'(gi), 32'd1);
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
